// File: rtl/hazard_scoreboard.sv
// Hazard controller for the 5-stage core: tracks EX/MEM/WB destinations and drives stalls,
// flushes and operand forward selects. Define HAZARD_PERF_CNT_EN to build the stall/flush counters.
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 4,
    parameter int PC_REG     = 15,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_r1_addr,
    input  logic [REG_ADDR_W-1:0] id_r2_addr,
    input  logic                  id_r1_used,
    input  logic                  id_r2_used,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic                  id_reg_write,
    input  logic                  id_mem_to_reg,
    input  logic                  ex_branch_taken,
    input  logic                  mem_busy,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  stall_e,
    output logic                  stall_m,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regWrite;
        logic                  memToReg;
        logic [REG_ADDR_W-1:0] r1;
        logic [REG_ADDR_W-1:0] r2;
        logic                  r1Used;
        logic                  r2Used;
    } entry_t;

    typedef enum logic [1:0] {
        MODE_RUN,
        MODE_STALL,
        MODE_FLUSH,
        MODE_FREEZE
    } mode_e;

    localparam logic [REG_ADDR_W-1:0] PcAddr   = REG_ADDR_W'(PC_REG);
    localparam logic [1:0]            LoadInit = 2'(LOAD_STALL - 1);

    entry_t     exEntry_q, exEntry_d;
    entry_t     memEntry_q, memEntry_d;
    entry_t     wbEntry_q, wbEntry_d;
    logic [1:0] loadCnt_q, loadCnt_d;
    logic       loadUse;
    mode_e      mode;
    logic       unusedWb;

    // A load sitting in MEM has no data yet, so it may only forward once it reaches WB.
    function automatic logic [1:0] fwdSelect(input logic [REG_ADDR_W-1:0] src,
                                             input logic                  used,
                                             input entry_t                memE,
                                             input entry_t                wbE);
        logic [1:0] sel;
        sel = 2'd0;
        if (used && src != PcAddr) begin
            if (memE.valid && memE.regWrite && !memE.memToReg && memE.rd == src) begin
                sel = 2'd2;
            end else if (wbE.valid && wbE.regWrite && wbE.rd == src) begin
                sel = 2'd1;
            end
        end
        return sel;
    endfunction

    always_comb begin
        loadUse = id_valid && exEntry_q.valid && exEntry_q.memToReg && (exEntry_q.rd != PcAddr) &&
                  ((id_r1_used && id_r1_addr == exEntry_q.rd) ||
                   (id_r2_used && id_r2_addr == exEntry_q.rd));
        mode = MODE_RUN;
        if (mem_busy) begin
            mode = MODE_FREEZE;
        end else if (ex_branch_taken) begin
            mode = MODE_FLUSH;
        end else if (loadUse || loadCnt_q != 2'd0) begin
            mode = MODE_STALL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exEntry_q  <= '0;
            memEntry_q <= '0;
            wbEntry_q  <= '0;
            loadCnt_q  <= 2'd0;
        end else begin
            exEntry_q  <= exEntry_d;
            memEntry_q <= memEntry_d;
            wbEntry_q  <= wbEntry_d;
            loadCnt_q  <= loadCnt_d;
        end
    end

    always_comb begin
        exEntry_d  = exEntry_q;
        memEntry_d = memEntry_q;
        wbEntry_d  = wbEntry_q;
        loadCnt_d  = loadCnt_q;
        case (mode)
            MODE_FREEZE: begin
                wbEntry_d = '0;
            end
            MODE_FLUSH: begin
                exEntry_d  = '0;
                memEntry_d = exEntry_q;
                wbEntry_d  = memEntry_q;
                loadCnt_d  = 2'd0;
            end
            MODE_STALL: begin
                exEntry_d  = '0;
                memEntry_d = exEntry_q;
                wbEntry_d  = memEntry_q;
                loadCnt_d  = (loadCnt_q != 2'd0) ? loadCnt_q - 2'd1 : LoadInit;
            end
            default: begin
                exEntry_d.valid    = id_valid & id_reg_write;
                exEntry_d.rd       = id_rd_addr;
                exEntry_d.regWrite = id_reg_write;
                exEntry_d.memToReg = id_mem_to_reg;
                exEntry_d.r1       = id_r1_addr;
                exEntry_d.r2       = id_r2_addr;
                exEntry_d.r1Used   = id_r1_used;
                exEntry_d.r2Used   = id_r2_used;
                memEntry_d         = exEntry_q;
                wbEntry_d          = memEntry_q;
            end
        endcase
    end

    always_comb begin
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        stall_e   = 1'b0;
        stall_m   = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        forward_a = 2'd0;
        forward_b = 2'd0;
        if (!rst) begin
            case (mode)
                MODE_FREEZE: begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    stall_m = 1'b1;
                end
                MODE_FLUSH: begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end
                MODE_STALL: begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
                default: begin
                end
            endcase
            if (exEntry_q.valid) begin
                forward_a = fwdSelect(exEntry_q.r1, exEntry_q.r1Used, memEntry_q, wbEntry_q);
                forward_b = fwdSelect(exEntry_q.r2, exEntry_q.r2Used, memEntry_q, wbEntry_q);
            end
        end
    end

    assign unusedWb = ^{wbEntry_q.r1, wbEntry_q.r2, wbEntry_q.r1Used, wbEntry_q.r2Used,
                        wbEntry_q.memToReg};

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stallCnt_q;
    logic [CNT_W-1:0] flushCnt_q;

    // Saturating event counters; they stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            if (stall_d && stallCnt_q != '1) begin
                stallCnt_q <= stallCnt_q + CNT_W'(1);
            end
            if (flush_e && flushCnt_q != '1) begin
                flushCnt_q <= flushCnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_count = stallCnt_q;
    assign flush_count = flushCnt_q;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule
